instr_fetch_unit: RTL and testbench

//   Fetch-side consumer of the program counter: owns the fetch PC, issues in-order

---
 rtl/instr_fetch_unit.sv | 214 +++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Owns the fetch PC and issues in-order word reads to instruction memory.
//   Returned words are buffered together with their PC and handed to decode
//   over a valid/ready handshake. A redirect from execute reloads the PC,
//   flushes the buffer, and discards every response still in flight.
//
//   Flow control is credit based. A request is only issued while
//   (buffered + outstanding) < BUF_DEPTH. This guarantees that every response
//   has a buffer slot, so imem responses never need back-pressure.
//
// Parameters
//   RESET_PC   fetch PC loaded on reset
//   BUF_DEPTH  buffer entries = max in-flight credit (power of 2, >= 2)
//
// Ports
//   clk, reset_n                 clock / async active-low reset
//   imem_req_valid/ready/addr    fetch request handshake, addr = fetch_pc
//   imem_rsp_valid/data          in-order response, never back-pressured
//   redirect_valid/redirect_pc   one-cycle redirect pulse and its target
//   dec_valid/ready/instr/pc     buffer head toward decode
//   fetch_pc                     next address to request
//   misalign_fault               only with FETCH_MISALIGN_EN
//
// Build option
//   FETCH_MISALIGN_EN : a redirect to a target that is not word aligned
//     parks the unit in FAULT. FAULT raises misalign_fault and issues no
//     requests until an aligned redirect arrives. Without the option, the
//     low two bits of redirect_pc are ignored.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [31:0] fetch_pc
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        misalign_fault
`endif
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] CREDIT = (CW+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
`ifdef FETCH_MISALIGN_EN
    ,
    S_FAULT = 2'd3
`endif
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_ent_t;

  state_t                        state, state_nxt;
  logic [CW-1:0]                 outstanding, outstanding_nxt;
  logic [CW-1:0]                 discard, discard_nxt;

  // Instruction buffer (PC + word) and the queue of PCs still in flight.
  fetch_ent_t [BUF_DEPTH-1:0]    buf_q;
  logic [AW-1:0]                 buf_wr, buf_rd;
  logic [CW-1:0]                 buf_cnt;
  logic [BUF_DEPTH-1:0][31:0]    pcq;
  logic [AW-1:0]                 pcq_wr, pcq_rd;

  logic [31:0]                   redir_tgt;
  logic [CW:0]                   credit_used;
  logic                          req_fire, rsp_drop, rsp_keep, pop;

  // -------------------------------------------------------------------------
  // Redirect target
  // -------------------------------------------------------------------------
`ifdef FETCH_MISALIGN_EN
  logic redir_misaligned;
  assign redir_tgt        = redirect_pc;
  assign redir_misaligned = |redirect_pc[1:0];
`else
  // Word fetch only: the byte offset of a target is meaningless here.
  logic unused_redir_lo;
  assign redir_tgt       = {redirect_pc[31:2], 2'b00};
  assign unused_redir_lo = ^redirect_pc[1:0];
`endif

  // -------------------------------------------------------------------------
  // Handshakes
  // -------------------------------------------------------------------------
  assign credit_used    = {1'b0, buf_cnt} + {1'b0, outstanding};
  assign imem_req_valid = (state == S_RUN) && !redirect_valid && (credit_used < CREDIT);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses that belong to a flushed fetch stream are counted by discard.
  // A response that lands in the redirect cycle itself is lost with the flush.
  assign rsp_drop = imem_rsp_valid && (discard != '0);
  assign rsp_keep = imem_rsp_valid && (discard == '0) && !redirect_valid;

`ifdef FETCH_MISALIGN_EN
  assign dec_valid      = (buf_cnt != '0) && (state != S_FAULT);
  assign misalign_fault = (state == S_FAULT);
`else
  assign dec_valid      = (buf_cnt != '0);
`endif
  assign pop       = dec_valid && dec_ready;
  // Head fields are forced to zero while empty so reset/flush shows clean 0s.
  assign dec_instr = dec_valid ? buf_q[buf_rd].instr : 32'h0;
  assign dec_pc    = dec_valid ? buf_q[buf_rd].pc    : 32'h0;

  // -------------------------------------------------------------------------
  // Counters
  // -------------------------------------------------------------------------
  always_comb begin
    outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    discard_nxt     = discard;
    if (redirect_valid)
      // Everything still outstanding after this cycle is now stale.
      discard_nxt = outstanding_nxt;
    else if (rsp_drop)
      discard_nxt = discard - 1'b1;
  end

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:         state_nxt = S_RUN;
      // DRAIN simply means stale responses are still due.
      S_RUN, S_DRAIN: state_nxt = (discard_nxt != '0) ? S_DRAIN : S_RUN;
`ifdef FETCH_MISALIGN_EN
      S_FAULT: if (redirect_valid)
                 state_nxt = (discard_nxt != '0) ? S_DRAIN : S_RUN;
`endif
      default:        state_nxt = S_IDLE;
    endcase
`ifdef FETCH_MISALIGN_EN
    if (redirect_valid && redir_misaligned)
      state_nxt = S_FAULT;
`endif
  end

  // -------------------------------------------------------------------------
  // Control state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      buf_wr      <= '0;
      buf_rd      <= '0;
      buf_cnt     <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;

      if (redirect_valid)
        fetch_pc <= redir_tgt;
      else if (req_fire)
        fetch_pc <= fetch_pc + 32'd4;

      if (redirect_valid) begin
        // The head popped this cycle (if any) has already left via dec_*.
        buf_wr  <= '0;
        buf_rd  <= '0;
        buf_cnt <= '0;
        pcq_wr  <= '0;
        pcq_rd  <= '0;
      end else begin
        if (req_fire) pcq_wr <= pcq_wr + 1'b1;
        if (rsp_keep) begin
          buf_wr <= buf_wr + 1'b1;
          pcq_rd <= pcq_rd + 1'b1;
        end
        if (pop) buf_rd <= buf_rd + 1'b1;
        buf_cnt <= buf_cnt + CW'(rsp_keep) - CW'(pop);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Storage (data only; validity is tracked by the pointers above)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (req_fire)
      pcq[pcq_wr] <= fetch_pc;
    if (rsp_keep)
      buf_q[buf_wr] <= '{pc: pcq[pcq_rd], instr: imem_rsp_data};
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit. The imem model has a fixed latency
//   and returns ~addr as the instruction word. The decode scoreboard expects
//   consecutive PCs from the reset or redirect target, with instr == ~pc.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          BUF_DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] fetch_pc;
`ifdef FETCH_MISALIGN_EN
  logic        misalign_fault;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .fetch_pc       (fetch_pc)
`ifdef FETCH_MISALIGN_EN
    ,
    .misalign_fault (misalign_fault)
`endif
  );

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct {
    int          lat;
    logic [31:0] rpc;
    int          rcyc;
    logic [31:0] exp_a0, exp_a1, exp_d0, exp_d1;
  } vec_t;

  int          total = 0, bad = 0;
  int          cyc, lat;
  int          first_req_cyc, first_dec_cyc;
  logic [31:0] exp_pc;
  pend_t       mem_q[$];
  logic [31:0] req_log[$], dec_log[$];
  logic        snap_req_valid, snap_rsp_valid, snap_dec_fire;
  logic [31:0] snap_dec_pc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rq(input int i);
    if (i < req_log.size()) return req_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] dq(input int i);
    if (i < dec_log.size()) return dec_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_req_valid"}, imem_req_valid, 1'b0);
    chk ({tag, "_req_addr"},  imem_req_addr, RESET_PC);
    chk1({tag, "_dec_valid"}, dec_valid, 1'b0);
    chk ({tag, "_dec_instr"}, dec_instr, 32'h0);
    chk ({tag, "_dec_pc"},    dec_pc, 32'h0);
    chk ({tag, "_fetch_pc"},  fetch_pc, RESET_PC);
`ifdef FETCH_MISALIGN_EN
    chk1({tag, "_fault"},     misalign_fault, 1'b0);
`endif
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic tick();
    logic        take, fire;
    logic [31:0] fa;
    take = 1'b0; fire = 1'b0; fa = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~mem_q[0].addr;
      take = 1'b1;
    end
    #1;
    snap_req_valid = imem_req_valid;
    snap_rsp_valid = imem_rsp_valid;
    snap_dec_fire  = dec_valid && dec_ready;
    snap_dec_pc    = dec_pc;
    if (imem_req_valid && imem_req_ready) begin
      fire = 1'b1;
      fa   = imem_req_addr;
      req_log.push_back(fa);
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (dec_valid && first_dec_cyc < 0) first_dec_cyc = cyc;
    if (dec_valid && dec_ready) begin
      dec_log.push_back(dec_pc);
      chk("sb_dec_pc", dec_pc, exp_pc);
      chk("sb_dec_instr", dec_instr, ~exp_pc);
      exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk);
    cyc++;
    if (take) mem_q.delete(0);
    if (fire) mem_q.push_back('{addr: fa, due: cyc + lat - 1});
    if (redirect_valid) begin
`ifdef FETCH_MISALIGN_EN
      exp_pc = redirect_pc;
`else
      exp_pc = {redirect_pc[31:2], 2'b00};
`endif
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input bit check_state);
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    mem_q.delete();
    req_log.delete();
    dec_log.delete();
    cyc = 0;
    exp_pc = RESET_PC;
    first_req_cyc = -1;
    first_dec_cyc = -1;
    @(negedge clk);
    #1;
    if (check_state) check_reset_outputs("rst");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    vec_t vt [4];
    // Redirect scenarios: {latency, target, cycle of redirect,
    //   first two request addrs after it, first two decoded PCs after it}
    vt[0] = '{1, 32'h0000_0100, 5, 32'h0000_0100, 32'h0000_0104, 32'h0000_0100, 32'h0000_0104};
    vt[1] = '{3, 32'h0000_0100, 3, 32'h0000_0100, 32'h0000_0104, 32'h0000_0100, 32'h0000_0104};
    vt[2] = '{1, 32'hFFFF_FFFC, 4, 32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000};
    vt[3] = '{2, 32'h0000_0040, 6, 32'h0000_0040, 32'h0000_0044, 32'h0000_0040, 32'h0000_0044};

    imem_req_ready = 1'b1;
    lat = 1;

    // Reset values, then a free-running stream with 1-cycle memory.
    do_reset(1'b1);
    repeat (12) tick();
    chk("t1_first_req_cyc", 32'(first_req_cyc), 32'd1);
    chk("t1_first_dec_cyc", 32'(first_dec_cyc), 32'd3);
    chk("t1_req0", rq(0), 32'h0);
    chk("t1_req1", rq(1), 32'h4);
    chk("t1_req2", rq(2), 32'h8);
    chk1("t1_ndec", dec_log.size() >= 4, 1'b1);

    // Decode stall: the credit fills the buffer, then fetch stops.
    do_reset(1'b0);
    dec_ready = 1'b0;
    repeat (10) tick();
    chk("t2_nreq", 32'(req_log.size()), 32'(BUF_DEPTH));
    chk("t2_fetch_pc", fetch_pc, 32'h8);
    chk1("t2_req_valid", imem_req_valid, 1'b0);
    chk1("t2_dec_valid", dec_valid, 1'b1);
    chk("t2_head_pc", dec_pc, 32'h0);
    req_log.delete();
    dec_ready = 1'b1;
    repeat (6) tick();
    chk("t2_d0", dq(0), 32'h0);
    chk("t2_d1", dq(1), 32'h4);
    chk("t2_resume", rq(0), 32'h8);

    // Redirect table
    for (int i = 0; i < 4; i++) begin
      do_reset(1'b0);
      lat = vt[i].lat;
      repeat (vt[i].rcyc) tick();
      redirect_pc    = vt[i].rpc;
      redirect_valid = 1'b1;
      tick();
      redirect_valid = 1'b0;
      chk1($sformatf("v%0d_no_req_on_redirect", i), snap_req_valid, 1'b0);
      req_log.delete();
      dec_log.delete();
      repeat (20) tick();
      chk($sformatf("v%0d_a0", i), rq(0), vt[i].exp_a0);
      chk($sformatf("v%0d_a1", i), rq(1), vt[i].exp_a1);
      chk($sformatf("v%0d_d0", i), dq(0), vt[i].exp_d0);
      chk($sformatf("v%0d_d1", i), dq(1), vt[i].exp_d1);
    end

    // Redirect in the same cycle as a response and a decode pop.
    do_reset(1'b0);
    lat = 1;
    repeat (3) tick();
    redirect_pc    = 32'h0000_0300;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk1("t4_req_valid", snap_req_valid, 1'b0);
    chk1("t4_rsp_valid", snap_rsp_valid, 1'b1);
    chk1("t4_pop", snap_dec_fire, 1'b1);
    chk("t4_pop_pc", snap_dec_pc, 32'h0);
    chk1("t4_dec_valid_next", dec_valid, 1'b0);
    dec_log.delete();
    repeat (8) tick();
    chk("t4_d0", dq(0), 32'h0000_0300);

`ifdef FETCH_MISALIGN_EN
    // A misaligned redirect parks the unit, and an aligned one releases it.
    do_reset(1'b0);
    lat = 1;
    repeat (4) tick();
    redirect_pc    = 32'h0000_0102;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    req_log.delete();
    repeat (5) tick();
    chk1("t6_fault", misalign_fault, 1'b1);
    chk("t6_no_req", 32'(req_log.size()), 32'd0);
    chk1("t6_dec_valid", dec_valid, 1'b0);
    redirect_pc    = 32'h0000_0200;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk1("t6_fault_clr", misalign_fault, 1'b0);
    dec_log.delete();
    repeat (8) tick();
    chk("t6_a0", rq(0), 32'h0000_0200);
    chk("t6_d0", dq(0), 32'h0000_0200);
`else
    // Without the fault option, a misaligned target is truncated to a word.
    do_reset(1'b0);
    lat = 1;
    repeat (4) tick();
    redirect_pc    = 32'h0000_0102;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    req_log.delete();
    dec_log.delete();
    repeat (8) tick();
    chk("t6_a0", rq(0), 32'h0000_0100);
    chk("t6_d0", dq(0), 32'h0000_0100);
`endif

    // Asynchronous reset in the middle of a stream.
    do_reset(1'b0);
    lat = 2;
    repeat (7) tick();
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
